// File: rtl/fir_feeder_pkg.sv
// Shared definitions for the FIR input feeder.
//   feeder_state_t : IDLE (waiting for a queued sample) / BUSY (filter working)
//   FEEDER_DEPTH   : default FIFO depth
//   FEEDER_TIMEOUT : default watchdog limit in BUSY cycles
//   WDOG_W         : watchdog counter width (covers any Timeout up to 1023)
package fir_feeder_pkg;

  typedef enum logic [0:0] {IDLE, BUSY} feeder_state_t;

  localparam int FEEDER_DEPTH   = 16;
  localparam int FEEDER_TIMEOUT = 1023;
  localparam int WDOG_W         = 10;

endpackage

// File: rtl/fir_input_feeder_if.sv
// Bundle of the feeder's sample-source and filter-side signals.
//   s_valid / s_data / s_ready : bursty source, valid/ready handshake
//   inputValid / FIR_input     : one-cycle issue pulse and held sample to the filter
//   outputValid                : filter completion strobe
//   fifo_count / busy / timeout_err : status
// Modport slave is the feeder's view; master is the environment's view.
interface fir_input_feeder_if #(
  parameter int InputWidth = 16,
  parameter int AddrWidth  = 4
);
  logic                         s_valid;
  logic signed [InputWidth-1:0] s_data;
  logic                         s_ready;
  logic                         inputValid;
  logic signed [InputWidth-1:0] FIR_input;
  logic                         outputValid;
  logic        [AddrWidth:0]    fifo_count;
  logic                         busy;
  logic                         timeout_err;

  modport slave (
    input  s_valid, s_data, outputValid,
    output s_ready, inputValid, FIR_input, fifo_count, busy, timeout_err
  );

  modport master (
    output s_valid, s_data, outputValid,
    input  s_ready, inputValid, FIR_input, fifo_count, busy, timeout_err
  );
endinterface

// File: rtl/feeder_sync_fifo.sv
// Synchronous FIFO holding samples waiting to be issued to the filter.
//   clk, rst : clock and asynchronous active-low reset
//   push/din : write din at the tail (ignored when full)
//   pop      : drop the head (ignored when empty)
//   dout     : current head, combinational read
//   count    : occupancy 0..Depth; full/empty decoded from it
module feeder_sync_fifo #(
  parameter int InputWidth = 16,
  parameter int Depth      = 16,
  parameter int AddrWidth  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic signed [InputWidth-1:0] din,
  output logic signed [InputWidth-1:0] dout,
  output logic        [AddrWidth:0]    count,
  output logic                         full,
  output logic                         empty
);

  logic signed [InputWidth-1:0] r_mem [Depth];
  logic        [AddrWidth-1:0]  r_wr_ptr;
  logic        [AddrWidth-1:0]  r_rd_ptr;
  logic        [AddrWidth:0]    r_count;
  logic                         w_do_push;
  logic                         w_do_pop;

  assign full      = (r_count == (AddrWidth+1)'(Depth));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Depth is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fir_input_feeder.sv
// Upstream feeder for the FIR filter. Samples from a bursty valid/ready
// source are queued in a FIFO and issued to the filter one at a time: a
// one-cycle inputValid pulse with FIR_input held, then the feeder waits for
// the filter's outputValid. A watchdog abandons a sample if the filter never
// answers within Timeout BUSY cycles and raises a sticky timeout_err.
//   clk, rst : clock and asynchronous active-low reset (shared with the filter)
//   bus      : fir_input_feeder_if.slave (source handshake, filter handshake, status)
module fir_input_feeder
  import fir_feeder_pkg::*;
#(
  parameter int InputWidth = 16,
  parameter int Depth      = FEEDER_DEPTH,
  parameter int AddrWidth  = 4,
  parameter int Timeout    = FEEDER_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_input_feeder_if.slave    bus
);

  feeder_state_t                r_state;
  feeder_state_t                w_state_nxt;
  logic        [WDOG_W-1:0]     r_wdog;
  logic        [WDOG_W-1:0]     w_wdog_nxt;
  logic                         r_input_valid;
  logic                         w_input_valid_nxt;
  logic signed [InputWidth-1:0] r_fir_input;
  logic                         r_busy;
  logic                         r_timeout_err;
  logic                         w_timeout_set;
  logic                         w_issue;

  logic signed [InputWidth-1:0] w_head;
  logic        [AddrWidth:0]    w_count;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;

  // Sample queue
  assign w_push      = bus.s_valid && !w_full;
  assign bus.s_ready = !w_full;

  feeder_sync_fifo #(
    .InputWidth (InputWidth),
    .Depth      (Depth),
    .AddrWidth  (AddrWidth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_issue),
    .din   (bus.s_data),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Issue / completion FSM
  always_comb begin
    w_state_nxt       = r_state;
    w_wdog_nxt        = r_wdog;
    w_input_valid_nxt = 1'b0;
    w_timeout_set     = 1'b0;
    w_issue           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_issue           = 1'b1;
          w_input_valid_nxt = 1'b1;
          w_wdog_nxt        = '0;
          w_state_nxt       = BUSY;
        end
      end
      BUSY: begin
        // A completion strobe coinciding with the issue pulse belongs to a
        // previous transaction, so it is not taken as completion.
        if (!r_input_valid && bus.outputValid) begin
          w_state_nxt = IDLE;
        end else if (r_wdog == WDOG_W'(Timeout - 1)) begin
          w_state_nxt   = IDLE;
          w_timeout_set = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_wdog        <= '0;
      r_input_valid <= 1'b0;
      r_fir_input   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wdog        <= w_wdog_nxt;
      r_input_valid <= w_input_valid_nxt;
      r_busy        <= (w_state_nxt == BUSY);
      r_timeout_err <= r_timeout_err | w_timeout_set;
      if (w_issue) r_fir_input <= w_head;
    end
  end

  assign bus.inputValid  = r_input_valid;
  assign bus.FIR_input   = r_fir_input;
  assign bus.fifo_count  = w_count;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fir_input_feeder.sv
module tb_fir_input_feeder;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_input_feeder_if #(.InputWidth(W), .AddrWidth(AW)) ifa ();
  fir_input_feeder_if #(.InputWidth(W), .AddrWidth(AW)) ifb ();

  // Instance A: long watchdog for functional tests; instance B: Timeout=8.
  fir_input_feeder #(.InputWidth(W), .Depth(D), .AddrWidth(AW), .Timeout(200)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  fir_input_feeder #(.InputWidth(W), .Depth(D), .AddrWidth(AW), .Timeout(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] iss_q [$];
  always @(negedge clk) if (ifa.inputValid) iss_q.push_back(ifa.FIR_input);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    int guard;
    int stall_sum;
    int base;
    int cnt;

    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.outputValid = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.outputValid = 1'b0;

    // Reset held with the source trying to push
    rst = 1'b0;
    ifa.s_valid = 1'b1; ifa.s_data = 16'h5555;
    ifb.s_valid = 1'b1; ifb.s_data = 16'h5555;
    repeat (3) tick();
    chk("rst_s_ready",    ifa.s_ready, 1);
    chk("rst_inputValid", ifa.inputValid, 0);
    chk("rst_FIR_input",  $unsigned(ifa.FIR_input), 0);
    chk("rst_count",      ifa.fifo_count, 0);
    chk("rst_timeout",    ifa.timeout_err, 0);
    chk("rst_busy",       ifa.busy, 0);
    chk("rst_count_b",    ifb.fifo_count, 0);
    ifa.s_valid = 1'b0; ifb.s_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    chk("post_rst_count", ifa.fifo_count, 0);
    chk("post_rst_iv",    ifa.inputValid, 0);

    // Single sample, filter answers ~70 cycles after the pulse
    ifa.s_valid = 1'b1; ifa.s_data = 16'h1234;
    tick();
    ifa.s_valid = 1'b0;
    chk("single_count_push", ifa.fifo_count, 1);
    chk("single_iv_early",   ifa.inputValid, 0);
    tick();
    chk("single_iv_rise",  ifa.inputValid, 1);
    chk("single_FIR",      $unsigned(ifa.FIR_input), 16'h1234);
    chk("single_busy",     ifa.busy, 1);
    chk("single_count_pop", ifa.fifo_count, 0);
    tick();
    chk("single_iv_fall", ifa.inputValid, 0);
    bad = 0;
    repeat (68) begin
      tick();
      if (ifa.inputValid || ifa.FIR_input != 16'h1234 || !ifa.busy) bad++;
    end
    chk("single_hold", bad, 0);
    ifa.outputValid = 1'b1;
    tick();
    ifa.outputValid = 1'b0;
    chk("single_busy_drop", ifa.busy, 0);
    chk("single_FIR_keep",  $unsigned(ifa.FIR_input), 16'h1234);
    chk("single_no_to",     ifa.timeout_err, 0);

    // Push and pop in the same cycle with one entry queued
    ifa.s_valid = 1'b1; ifa.s_data = 16'hA1A1;
    tick();
    ifa.s_data = 16'hB2B2;
    tick();
    ifa.s_valid = 1'b0;
    chk("sim_first_FIR",   $unsigned(ifa.FIR_input), 16'hA1A1);
    chk("sim_first_count", ifa.fifo_count, 1);
    tick();
    ifa.outputValid = 1'b1;
    tick();
    ifa.outputValid = 1'b0;
    chk("sim_idle", ifa.busy, 0);
    ifa.s_valid = 1'b1; ifa.s_data = 16'hBEEF;
    tick();
    ifa.s_valid = 1'b0;
    chk("sim_count_same", ifa.fifo_count, 1);
    chk("sim_iv",         ifa.inputValid, 1);
    chk("sim_old_head",   $unsigned(ifa.FIR_input), 16'hB2B2);
    tick();
    ifa.outputValid = 1'b1;
    tick();
    ifa.outputValid = 1'b0;
    tick();
    chk("sim_next_iv",    ifa.inputValid, 1);
    chk("sim_next_FIR",   $unsigned(ifa.FIR_input), 16'hBEEF);
    chk("sim_next_count", ifa.fifo_count, 0);
    tick();
    ifa.outputValid = 1'b1;
    tick();
    ifa.outputValid = 1'b0;

    // Fill with the filter stalled; sample 0 goes straight out, 1..16 fill
    // the FIFO, sample 17 must wait for the next pop (after a timeout)
    base = iss_q.size();
    stall_sum = 0;
    for (int i = 0; i < 18; i++) begin
      ifa.s_valid = 1'b1;
      ifa.s_data  = 16'(i);
      if (i == 17) begin
        chk("fill_full_count", ifa.fifo_count, 16);
        chk("fill_s_ready",    ifa.s_ready, 0);
      end
      guard = 0;
      while (!ifa.s_ready && guard < 400) begin
        tick();
        guard++;
      end
      if (i < 17) stall_sum += guard;
      else begin
        chk("fill_held_bound",   guard < 400, 1);
        chk("fill_held_timeout", ifa.timeout_err, 1);
        chk("fill_held_count",   ifa.fifo_count, 15);
      end
      tick();
    end
    ifa.s_valid = 1'b0;
    chk("fill_no_stall",   stall_sum, 0);
    chk("fill_count_after", ifa.fifo_count, 16);
    guard = 0;
    while (iss_q.size() < base + 18 && guard < 2000) begin
      ifa.outputValid = ifa.busy && !ifa.inputValid;
      tick();
      guard++;
    end
    ifa.outputValid = 1'b1;
    tick();
    ifa.outputValid = 1'b0;
    chk("fill_issue_count", iss_q.size() - base, 18);
    for (int i = 0; i < 18; i++) begin
      if (base + i < iss_q.size()) chk($sformatf("fill_order_%0d", i), iss_q[base+i], i);
      else chk($sformatf("fill_order_%0d", i), 32'hFFFF_FFFF, i);
    end
    chk("fill_drained", ifa.fifo_count, 0);

    // Watchdog on instance B (Timeout=8), two samples queued
    chk("wd_pre_to", ifb.timeout_err, 0);
    ifb.s_valid = 1'b1; ifb.s_data = 16'h0101;
    tick();
    ifb.s_data = 16'h0202;
    tick();
    ifb.s_valid = 1'b0;
    chk("wd_first_iv",    ifb.inputValid, 1);
    chk("wd_first_count", ifb.fifo_count, 1);
    cnt = 0;
    while (ifb.busy && cnt < 50) begin
      cnt++;
      tick();
    end
    chk("wd_busy_cycles", cnt, 8);
    chk("wd_to_set",      ifb.timeout_err, 1);
    chk("wd_idle_count",  ifb.fifo_count, 1);
    tick();
    chk("wd_second_iv",  ifb.inputValid, 1);
    chk("wd_second_FIR", $unsigned(ifb.FIR_input), 16'h0202);
    repeat (10) tick();
    chk("wd_sticky", ifb.timeout_err, 1);
    chk("wd_idle",   ifb.busy, 0);
    chk("wd_empty",  ifb.fifo_count, 0);

    // Asynchronous reset while BUSY with samples queued
    ifa.s_valid = 1'b1;
    ifa.s_data = 16'hC001; tick();
    ifa.s_data = 16'hC002; tick();
    ifa.s_data = 16'hC003; tick();
    ifa.s_valid = 1'b0;
    chk("mid_busy",  ifa.busy, 1);
    chk("mid_count", ifa.fifo_count, 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy",  ifa.busy, 0);
    chk("mid_rst_count", ifa.fifo_count, 0);
    chk("mid_rst_FIR",   $unsigned(ifa.FIR_input), 0);
    chk("mid_rst_to",    ifa.timeout_err, 0);
    chk("mid_rst_to_b",  ifb.timeout_err, 0);
    tick();
    #3 rst = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (ifa.inputValid || ifa.busy) bad++;
    end
    chk("mid_no_issue", bad, 0);
    ifa.s_valid = 1'b1; ifa.s_data = 16'h7777;
    tick();
    ifa.s_valid = 1'b0;
    tick();
    chk("mid_new_iv",  ifa.inputValid, 1);
    chk("mid_new_FIR", $unsigned(ifa.FIR_input), 16'h7777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL tb_time_limit: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
